// File: rtl/gcd_ctrl.sv
// Sequencing FSM for the subtractive GCD datapath: loads operands, steers subtraction, reports result/error.
// Optional iteration watchdog enabled by defining GCD_CTRL_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | waiting for start
// LOAD_A  | load A from input bus
// LOAD_B  | load B from input bus
// CMP     | evaluate comparator/zero flags
// SUB_A   | A <= A - B
// SUB_B   | B <= B - A
// DONE    | result valid, wait for ack
// ERR     | error reported in err_code, wait for ack
module gcd_ctrl #(
  parameter int ITER_W   = 8,
  parameter int MAX_ITER = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              ack,
  input  logic              lt,
  input  logic              gt,
  input  logic              eq,
  input  logic              a_zero,
  input  logic              b_zero,
  output logic              ld_a,
  output logic              ld_b,
  output logic              sel_in,
  output logic              sel_sub,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ITER_W-1:0] iter_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_CMP, S_SUB_A, S_SUB_B, S_DONE, S_ERR
  } state_e;

  localparam logic [1:0] CODE_NONE = 2'b00;
  localparam logic [1:0] CODE_ZERO = 2'b01;
  localparam logic [1:0] CODE_TMO  = 2'b10;
  localparam logic [1:0] CODE_FLAG = 2'b11;
  localparam logic [ITER_W-1:0] ITER_MAX_C = ITER_W'(MAX_ITER);
  localparam logic [ITER_W-1:0] ITER_SAT_C = '1;

  state_e              state_q, state_d;
  logic [ITER_W-1:0]   iter_q, iter_d, iter_inc;
  logic [1:0]          code_q, code_d;
  logic                flags_onehot;
  logic                timeout;

  assign flags_onehot = ({lt, gt, eq} == 3'b100) || ({lt, gt, eq} == 3'b010) ||
                        ({lt, gt, eq} == 3'b001);
  assign iter_inc     = (iter_q == ITER_SAT_C) ? iter_q : iter_q + 1'b1;

`ifdef GCD_CTRL_TIMEOUT_EN
  assign timeout = (iter_q == ITER_MAX_C) && !eq;
`else
  // MAX_ITER is still accepted so both builds share one parameter list.
  logic unused_max_iter;
  assign unused_max_iter = ^ITER_MAX_C;
  assign timeout         = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      iter_q  <= '0;
      code_q  <= CODE_NONE;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      code_q  <= code_d;
    end
  end

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    code_d  = code_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD_A;
          iter_d  = '0;
          code_d  = CODE_NONE;
        end
      end
      S_LOAD_A: state_d = S_LOAD_B;
      S_LOAD_B: state_d = S_CMP;
      S_CMP: begin
        if (a_zero || b_zero) begin
          state_d = S_ERR;
          code_d  = CODE_ZERO;
        end else if (!flags_onehot) begin
          state_d = S_ERR;
          code_d  = CODE_FLAG;
        end else if (eq) begin
          state_d = S_DONE;
        end else if (timeout) begin
          state_d = S_ERR;
          code_d  = CODE_TMO;
        end else if (gt) begin
          state_d = S_SUB_A;
        end else begin
          state_d = S_SUB_B;
        end
      end
      S_SUB_A, S_SUB_B: begin
        state_d = S_CMP;
        iter_d  = iter_inc;
      end
      S_DONE, S_ERR: begin
        if (ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs: decoded from the state register only.
  always_comb begin
    ld_a    = 1'b0;
    ld_b    = 1'b0;
    sel_in  = 1'b0;
    sel_sub = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    case (state_q)
      S_LOAD_A: begin ld_a = 1'b1; sel_in = 1'b1; busy = 1'b1; end
      S_LOAD_B: begin ld_b = 1'b1; sel_in = 1'b1; busy = 1'b1; end
      S_CMP:    busy = 1'b1;
      S_SUB_A:  begin ld_a = 1'b1; busy = 1'b1; end
      S_SUB_B:  begin ld_b = 1'b1; sel_sub = 1'b1; busy = 1'b1; end
      S_DONE:   done = 1'b1;
      S_ERR:    err = 1'b1;
      default:  ;
    endcase
  end

  assign err_code = code_q;
  assign iter_cnt = iter_q;

endmodule
